// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch stage: program counter, ROM address and instruction register
module pc_fetch_unit #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 9,
    parameter int START_PC    = 0,
    parameter int PROG_LAST   = 34
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [7:0]             branch_offset,
    input  logic                   jump,
    input  logic [PC_WIDTH-1:0]    jump_target,
    input  logic                   halt_req,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic [INSTR_WIDTH-1:0] ir_out,
    output logic [PC_WIDTH-1:0]    ir_pc,
    output logic                   ir_valid,
    output logic                   halted,
    output logic [15:0]            fetch_count
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [PC_WIDTH-1:0] START_ADDR = PC_WIDTH'(START_PC);
    localparam logic [PC_WIDTH-1:0] LAST_ADDR  = PC_WIDTH'(PROG_LAST);

    state_t                  state, state_nx;
    logic [PC_WIDTH-1:0]     pc_nx, ir_pc_nx, branch_dest;
    logic [INSTR_WIDTH-1:0]  ir_nx;
    logic                    ir_valid_nx, halted_nx;
    logic [15:0]             count_nx;

    // Branches are relative to the instruction currently held in the IR.
    assign branch_dest = ir_pc + {{(PC_WIDTH-8){branch_offset[7]}}, branch_offset};

    always_comb begin
        state_nx    = state;
        pc_nx       = pc_out;
        ir_nx       = ir_out;
        ir_pc_nx    = ir_pc;
        ir_valid_nx = ir_valid;
        halted_nx   = halted;
        count_nx    = fetch_count;
        case (state)
            IDLE: begin
                state_nx    = RUN;
                ir_valid_nx = 1'b0;
            end
            RUN: begin
                if (halt_req) begin
                    state_nx    = HALT;
                    halted_nx   = 1'b1;
                    ir_valid_nx = 1'b0;
                end else if (jump) begin
                    pc_nx       = jump_target;
                    ir_valid_nx = 1'b0;
                end else if (branch_taken) begin
                    pc_nx       = branch_dest;
                    ir_valid_nx = 1'b0;
                end else if (stall) begin
                    pc_nx       = pc_out;
                end else if (pc_out > LAST_ADDR) begin
                    state_nx    = HALT;
                    halted_nx   = 1'b1;
                    ir_valid_nx = 1'b0;
                end else begin
                    ir_nx       = instr_in;
                    ir_pc_nx    = pc_out;
                    ir_valid_nx = 1'b1;
                    pc_nx       = pc_out + 1'b1;
                    if (fetch_count != 16'hFFFF)
                        count_nx = fetch_count + 16'd1;
                end
            end
            HALT: begin
                halted_nx   = 1'b1;
                ir_valid_nx = 1'b0;
            end
            default: begin
                state_nx    = IDLE;
                ir_valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc_out      <= START_ADDR;
            ir_out      <= '0;
            ir_pc       <= '0;
            ir_valid    <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_nx;
            pc_out      <= pc_nx;
            ir_out      <= ir_nx;
            ir_pc       <= ir_pc_nx;
            ir_valid    <= ir_valid_nx;
            halted      <= halted_nx;
            fetch_count <= count_nx;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized fetch-unit bench against a behavioural reference model
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_offset = 8'h00;
    logic        jump = 1'b0;
    logic [15:0] jump_target = 16'h0000;
    logic        halt_req = 1'b0;
    logic [8:0]  instr_in;
    logic [15:0] pc_out;
    logic [8:0]  ir_out;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [8:0]  rom [0:65535];
    assign instr_in = rom[pc_out];

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
        .halt_req(halt_req), .instr_in(instr_in), .pc_out(pc_out), .ir_out(ir_out),
        .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted), .fetch_count(fetch_count)
    );

    // Reference model: mode 0 = just reset, 1 = fetching, 2 = stopped.
    int m_mode, m_pc, m_ir, m_irpc, m_valid, m_halted, m_cnt;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_mode = 0; m_pc = 0; m_ir = 0; m_irpc = 0; m_valid = 0; m_halted = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_valid = 0;
        end else if (m_mode == 2) begin
            m_valid = 0;
        end else if (halt_req) begin
            m_mode = 2; m_halted = 1; m_valid = 0;
        end else if (jump) begin
            m_pc = int'(jump_target); m_valid = 0;
        end else if (branch_taken) begin
            m_pc = (m_irpc + int'($signed(branch_offset)) + 65536) % 65536; m_valid = 0;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (m_pc > 34) begin
            m_mode = 2; m_halted = 1; m_valid = 0;
        end else begin
            m_ir = int'(rom[m_pc]); m_irpc = m_pc; m_valid = 1;
            m_pc = (m_pc + 1) % 65536;
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("pc_out", 32'(pc_out), m_pc);
        check("ir_out", 32'(ir_out), m_ir);
        check("ir_pc", 32'(ir_pc), m_irpc);
        check("ir_valid", 32'(ir_valid), m_valid);
        check("halted", 32'(halted), m_halted);
        check("fetch_count", 32'(fetch_count), m_cnt);
    endtask

    task automatic quiet();
        reset = 0; stall = 0; branch_taken = 0; jump = 0; halt_req = 0;
    endtask

    task automatic do_reset();
        reset = 1; step(); quiet();
    endtask

    task automatic run_until_pc(input int k);
        for (int n = 0; n < 100 && int'(pc_out) != k; n++) step();
        check("reach_pc", 32'(pc_out), k);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 9'($urandom);

        // Reset state, then clean sequential run
        do_reset();
        check("rst_pc", 32'(pc_out), 0);
        check("rst_valid", 32'(ir_valid), 0);
        check("rst_cnt", 32'(fetch_count), 0);
        step();
        check("idle_pc", 32'(pc_out), 0);
        check("idle_valid", 32'(ir_valid), 0);
        step();
        check("first_ir", 32'(ir_out), 32'(rom[0]));
        check("first_cnt", 32'(fetch_count), 1);

        // Stall three cycles at pc 5
        run_until_pc(5);
        stall = 1;
        repeat (3) step();
        check("stall_pc", 32'(pc_out), 5);
        check("stall_irpc", 32'(ir_pc), 4);
        check("stall_cnt", 32'(fetch_count), 5);
        stall = 0;
        step();
        check("unstall_ir", 32'(ir_out), 32'(rom[5]));

        // Backward branch from ir_pc 10
        run_until_pc(11);
        check("br_irpc", 32'(ir_pc), 10);
        branch_taken = 1; branch_offset = 8'hFC;
        step();
        branch_taken = 0;
        check("br_pc", 32'(pc_out), 6);
        check("br_squash", 32'(ir_valid), 0);
        step();
        check("br_ir", 32'(ir_out), 32'(rom[6]));
        check("br_irpc2", 32'(ir_pc), 6);

        // Jump outranks branch and stall
        jump = 1; jump_target = 16'h0020; branch_taken = 1; stall = 1;
        step();
        quiet();
        check("jmp_pc", 32'(pc_out), 32);
        check("jmp_valid", 32'(ir_valid), 0);
        step();
        check("jmp_ir", 32'(ir_out), 32'(rom[32]));

        // Free run off the end of the program
        do_reset();
        repeat (37) step();
        check("end_pc", 32'(pc_out), 35);
        step();
        check("end_halted", 32'(halted), 1);
        check("end_valid", 32'(ir_valid), 0);
        jump = 1; jump_target = 16'h0003; branch_taken = 1;
        repeat (3) step();
        quiet();
        check("halt_pc", 32'(pc_out), 35);
        check("halt_cnt", 32'(fetch_count), 35);

        // Reset out of HALT, and again mid-run
        do_reset();
        check("rh_halted", 32'(halted), 0);
        check("rh_cnt", 32'(fetch_count), 0);
        run_until_pc(12);
        do_reset();
        check("rm_pc", 32'(pc_out), 0);
        check("rm_valid", 32'(ir_valid), 0);
        repeat (2) step();
        check("rm_resume", 32'(ir_valid), 1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 79) == 0);
            halt_req      = ($urandom_range(0, 149) == 0);
            jump          = ($urandom_range(0, 15) == 0);
            jump_target   = 16'($urandom_range(0, 40));
            branch_taken  = ($urandom_range(0, 9) == 0);
            branch_offset = 8'($urandom);
            stall         = ($urandom_range(0, 3) == 0);
            step();
        end
        quiet();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
